// File: rtl/move_scheduler.sv
// move_scheduler: round-robin arbiter between two move sources (board keys and
// PS/2 decoder). It issues single-cycle direction commands to the 3x3 grid FSM,
// and rate-limits them with a cooldown. A shadow copy of the grid position lets
// it reject moves that would leave the grid.
module move_scheduler #(
    parameter int unsigned COOLDOWN  = 25_000_000,
    parameter int unsigned CNT_W     = 25,
    parameter int unsigned CNT_MOVES = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable_i,
    input  logic                 req_a_i,
    input  logic [2:0]           dir_a_i,
    output logic                 ack_a_o,
    input  logic                 req_b_i,
    input  logic [2:0]           dir_b_i,
    output logic                 ack_b_o,
    output logic [2:0]           move_dir_o,
    output logic                 blocked_o,
    output logic [3:0]           pos_o,
    output logic [CNT_MOVES-1:0] move_count_o,
    output logic                 busy_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_COOL  = 2'd2
    } state_e;

    localparam logic [2:0] DIR_IDLE  = 3'd0;
    localparam logic [2:0] DIR_UP    = 3'd1;
    localparam logic [2:0] DIR_DOWN  = 3'd2;
    localparam logic [2:0] DIR_RIGHT = 3'd3;
    localparam logic [2:0] DIR_LEFT  = 3'd4;

    localparam logic [CNT_W-1:0] COOL_LOAD = CNT_W'(COOLDOWN - 1);

    state_e               state_q, state_d;
    logic [2:0]           dir_q, dir_d;
    logic                 last_b_q, last_b_d;
    logic                 ack_a_q, ack_a_d;
    logic                 ack_b_q, ack_b_d;
    logic                 blocked_q, blocked_d;
    logic [3:0]           pos_q, pos_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [CNT_MOVES-1:0] mcount_q, mcount_d;

    logic                 any_req;
    logic                 pick_b;
    logic [2:0]           sel_dir;
    logic                 edge_hit;
    logic                 sel_legal;

    // Arbitration: pick the source and check its direction against the shadow position.
    always_comb begin
        // NOTE: every combinational output gets a default first so that no path infers a latch.
        edge_hit = 1'b0;
        any_req  = enable_i && (req_a_i || req_b_i);
        // B wins if it is alone, or if both request and A was granted last.
        pick_b   = req_b_i && (!req_a_i || !last_b_q);
        sel_dir  = pick_b ? dir_b_i : dir_a_i;
        case (sel_dir)
            DIR_UP:    edge_hit = (pos_q < 4'd3);
            DIR_DOWN:  edge_hit = (pos_q >= 4'd6);
            DIR_LEFT:  edge_hit = (pos_q == 4'd0) || (pos_q == 4'd3) || (pos_q == 4'd6);
            DIR_RIGHT: edge_hit = (pos_q == 4'd2) || (pos_q == 4'd5) || (pos_q == 4'd8);
            default:   edge_hit = 1'b0;
        endcase
        sel_legal = (sel_dir >= DIR_UP) && (sel_dir <= DIR_LEFT) && !edge_hit;
    end

    // State register plus the datapath registers; reset forces every one of them.
    always_ff @(posedge clk) begin
        // NOTE: the reset is synchronous and clears all state, including the shadow position and counters.
        if (reset) begin
            state_q   <= S_IDLE;
            dir_q     <= DIR_IDLE;
            last_b_q  <= 1'b1;
            ack_a_q   <= 1'b0;
            ack_b_q   <= 1'b0;
            blocked_q <= 1'b0;
            pos_q     <= 4'd0;
            cnt_q     <= '0;
            mcount_q  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so that every register samples pre-edge values.
            state_q   <= state_d;
            dir_q     <= dir_d;
            last_b_q  <= last_b_d;
            ack_a_q   <= ack_a_d;
            ack_b_q   <= ack_b_d;
            blocked_q <= blocked_d;
            pos_q     <= pos_d;
            cnt_q     <= cnt_d;
            mcount_q  <= mcount_d;
        end
    end

    // Next-state logic for the IDLE / ISSUE / COOL sequence.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (any_req && sel_legal) state_d = S_ISSUE;
            S_ISSUE: state_d = S_COOL;
            S_COOL:  if (cnt_q == '0) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next values: grant bookkeeping, ack/blocked pulses, position, cooldown.
    always_comb begin
        dir_d     = dir_q;
        last_b_d  = last_b_q;
        ack_a_d   = 1'b0;
        ack_b_d   = 1'b0;
        blocked_d = 1'b0;
        pos_d     = pos_q;
        cnt_d     = cnt_q;
        mcount_d  = mcount_q;
        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    dir_d     = sel_dir;
                    last_b_d  = pick_b;
                    // Every grant is acked one cycle later, whether it moves, idles or is rejected.
                    ack_a_d   = !pick_b;
                    ack_b_d   = pick_b;
                    blocked_d = (sel_dir != DIR_IDLE) && !sel_legal;
                end
            end
            S_ISSUE: begin
                case (dir_q)
                    DIR_UP:    pos_d = pos_q - 4'd3;
                    DIR_DOWN:  pos_d = pos_q + 4'd3;
                    DIR_RIGHT: pos_d = pos_q + 4'd1;
                    DIR_LEFT:  pos_d = pos_q - 4'd1;
                    default:   pos_d = pos_q;
                endcase
                mcount_d = mcount_q + 1'b1;
                cnt_d    = COOL_LOAD;
            end
            S_COOL: begin
                if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
            end
            default: ;
        endcase
    end

    // Outputs decoded from the current state.
    always_comb begin
        move_dir_o = (state_q == S_ISSUE) ? dir_q : DIR_IDLE;
        busy_o     = (state_q != S_IDLE);
    end

    assign ack_a_o      = ack_a_q;
    assign ack_b_o      = ack_b_q;
    assign blocked_o    = blocked_q;
    assign pos_o        = pos_q;
    assign move_count_o = mcount_q;

endmodule

// File: tb/tb_move_scheduler.sv
// Directed testbench for move_scheduler with a short cooldown.
module tb_move_scheduler;

    localparam int COOLDOWN  = 4;
    localparam int CNT_W     = 3;
    localparam int CNT_MOVES = 8;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 enable = 1'b1;
    logic                 req_a = 1'b0;
    logic [2:0]           dir_a = 3'd0;
    logic                 req_b = 1'b0;
    logic [2:0]           dir_b = 3'd0;
    logic                 ack_a, ack_b, blocked, busy;
    logic [2:0]           move_dir;
    logic [3:0]           pos;
    logic [CNT_MOVES-1:0] move_count;

    int vec_cnt = 0;
    int err_cnt = 0;

    move_scheduler #(
        .COOLDOWN (COOLDOWN),
        .CNT_W    (CNT_W),
        .CNT_MOVES(CNT_MOVES)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable_i    (enable),
        .req_a_i     (req_a),
        .dir_a_i     (dir_a),
        .ack_a_o     (ack_a),
        .req_b_i     (req_b),
        .dir_b_i     (dir_b),
        .ack_b_o     (ack_b),
        .move_dir_o  (move_dir),
        .blocked_o   (blocked),
        .pos_o       (pos),
        .move_count_o(move_count),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        vec_cnt++;
        if (got != exp) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-edge request from source A (src_b=0) or B (src_b=1).
    task automatic pulse(input bit src_b, input logic [2:0] d);
        if (src_b) begin
            req_b = 1'b1;
            dir_b = d;
        end else begin
            req_a = 1'b1;
            dir_a = d;
        end
        tick();
        req_a = 1'b0;
        req_b = 1'b0;
    endtask

    task automatic expect_out(input string tag, input int md, input int aa,
                              input int ab, input int bl, input int bs);
        check({tag, " move_dir"}, int'(move_dir), md);
        check({tag, " ack_a"},    int'(ack_a),    aa);
        check({tag, " ack_b"},    int'(ack_b),    ab);
        check({tag, " blocked"},  int'(blocked),  bl);
        check({tag, " busy"},     int'(busy),     bs);
    endtask

    // Counts busy cycles from the current one until IDLE, bounded.
    task automatic wait_idle(input string tag, input int exp_cycles);
        int n;
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            tick();
        end
        check({tag, " busy cycles"}, n, exp_cycles);
    endtask

    task automatic check_reset_vals(input string tag);
        expect_out(tag, 0, 0, 0, 0, 0);
        check({tag, " pos"},   int'(pos),        0);
        check({tag, " count"}, int'(move_count), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [2:0] walk_dir [4];
        int         walk_pos [4];
        int         n;
        walk_dir = '{3'd2, 3'd2, 3'd3, 3'd3};
        walk_pos = '{3, 6, 7, 8};

        // Reset values
        tick();
        tick();
        check_reset_vals("reset");
        reset = 1'b0;

        // Up from pos 0 is an edge move: ack + blocked, nothing else
        pulse(1'b1, 3'd1);
        expect_out("t2 up@0", 0, 0, 1, 1, 0);
        tick();
        check("t2 pos", int'(pos), 0);
        expect_out("t2 after", 0, 0, 0, 0, 0);

        // Legal Right move from A
        pulse(1'b0, 3'd3);
        expect_out("t1 issue", 3, 1, 0, 0, 1);
        tick();
        check("t1 pos", int'(pos), 1);
        check("t1 count", int'(move_count), 1);
        expect_out("t1 cool", 0, 0, 0, 0, 1);
        wait_idle("t1", COOLDOWN);

        // Illegal code, then Idle code
        pulse(1'b0, 3'd6);
        expect_out("t5 illegal", 0, 1, 0, 1, 0);
        tick();
        check("t5 pos", int'(pos), 1);
        check("t5 count", int'(move_count), 1);
        pulse(1'b0, 3'd0);
        expect_out("t5 idle", 0, 1, 0, 0, 0);
        tick();

        // enable=0 holds off a pending request
        enable = 1'b0;
        req_a  = 1'b1;
        dir_a  = 3'd2;
        tick();
        tick();
        tick();
        expect_out("en0", 0, 0, 0, 0, 0);
        enable = 1'b1;
        tick();
        req_a = 1'b0;
        expect_out("en1", 2, 1, 0, 0, 1);
        wait_idle("en1", 1 + COOLDOWN);
        check("en1 pos", int'(pos), 4);
        check("en1 count", int'(move_count), 2);

        // Walk to the corner, then edge rejects and a Left
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_vals("t4 reset");
        for (int i = 0; i < 4; i++) begin
            pulse(1'b0, walk_dir[i]);
            check("t4 walk dir", int'(move_dir), int'(walk_dir[i]));
            wait_idle("t4 walk", 1 + COOLDOWN);
            check("t4 walk pos", int'(pos), walk_pos[i]);
        end
        pulse(1'b0, 3'd3);
        expect_out("t4 right@8", 0, 1, 0, 1, 0);
        tick();
        pulse(1'b1, 3'd2);
        expect_out("t4 down@8", 0, 0, 1, 1, 0);
        tick();
        check("t4 pos hold", int'(pos), 8);
        pulse(1'b0, 3'd4);
        expect_out("t4 left", 4, 1, 0, 0, 1);
        wait_idle("t4 left", 1 + COOLDOWN);
        check("t4 pos", int'(pos), 7);
        check("t4 count", int'(move_count), 5);

        // Both request from reset: A first, B after cooldown
        reset = 1'b1;
        req_a = 1'b1;
        dir_a = 3'd2;
        req_b = 1'b1;
        dir_b = 3'd3;
        tick();
        reset = 1'b0;
        tick();
        expect_out("t3 A", 2, 1, 0, 0, 1);
        req_a = 1'b0;
        n = 0;
        do begin
            tick();
            n++;
        end while (move_dir == 3'd0 && n < 50);
        check("t3 spacing", n, COOLDOWN + 2);
        expect_out("t3 B", 3, 0, 1, 0, 1);
        req_b = 1'b0;
        wait_idle("t3 B", 1 + COOLDOWN);
        check("t3 pos", int'(pos), 4);
        check("t3 count", int'(move_count), 2);

        // Reset mid-COOL with B pending
        pulse(1'b0, 3'd1);
        check("t6 up dir", int'(move_dir), 1);
        tick();
        req_b = 1'b1;
        dir_b = 3'd3;
        tick();
        check("t6 B waits", int'(ack_b), 0);
        check("t6 busy", int'(busy), 1);
        reset = 1'b1;
        tick();
        check_reset_vals("t6 reset");
        reset = 1'b0;
        tick();
        req_b = 1'b0;
        expect_out("t6 B", 3, 0, 1, 0, 1);
        wait_idle("t6 B", 1 + COOLDOWN);
        check("t6 pos", int'(pos), 1);
        check("t6 count", int'(move_count), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
